// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module  : wb_arbiter_pkg
// Brief   : Shared widths and writeback source encoding for the writeback slice
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int WB_WIDTH     = 32;
    localparam int WB_REG_WIDTH = 5;
    localparam int WB_DEPTH     = 2;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LSU  = 2'd1,
        SRC_ALU  = 2'd2
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module  : wb_fifo
// Brief   : In-order {rd,data} FIFO; exposes every entry in age order (0 = head)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH     = WB_WIDTH,
    parameter int REG_WIDTH = WB_REG_WIDTH,
    parameter int DEPTH     = WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [REG_WIDTH-1:0]         push_rd,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH*REG_WIDTH-1:0]   ent_rd,
    output logic [DEPTH*WIDTH-1:0]       ent_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        w_count;
    logic [REG_WIDTH-1:0] r_mem_rd   [DEPTH];
    logic [WIDTH-1:0]     r_mem_data [DEPTH];
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_rd[r_wr_ptr[AW-1:0]]   <= push_rd;
            r_mem_data[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        localparam logic [AW-1:0] c_off = AW'(gi);
        logic [AW-1:0] w_idx;
        assign w_idx         = r_rd_ptr[AW-1:0] + c_off;
        assign ent_valid[gi] = (w_count > PW'(gi));
        assign ent_rd[gi*REG_WIDTH +: REG_WIDTH] = r_mem_rd[w_idx];
        assign ent_data[gi*WIDTH +: WIDTH]       = r_mem_data[w_idx];
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module  : wb_arbiter
// Brief   : Writeback arbiter: LSU results beat queued ALU results onto the
//           single register-file write port; publishes pending-write mask.
//           Optional bypass search enabled by defining WB_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH     = WB_WIDTH,
    parameter int REG_WIDTH = WB_REG_WIDTH,
    parameter int DEPTH     = WB_DEPTH,
    parameter int REG_NUM   = 1 << REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic                 alu_wen,
    input  logic [REG_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]     alu_data,
    input  logic                 lsu_valid,
    input  logic [REG_WIDTH-1:0] lsu_rd,
    input  logic [WIDTH-1:0]     lsu_data,
    output logic                 rf_wen,
    output logic [REG_WIDTH-1:0] rf_waddr,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic [REG_NUM-1:0]   pend_mask,
    input  logic [REG_WIDTH-1:0] byp_raddr1,
    input  logic [REG_WIDTH-1:0] byp_raddr2,
    output logic                 byp_hit1,
    output logic                 byp_hit2,
    output logic [WIDTH-1:0]     byp_data1,
    output logic [WIDTH-1:0]     byp_data2
);

    logic                       w_full;
    logic                       w_empty;
    logic [DEPTH-1:0]           w_ent_valid;
    logic [DEPTH*REG_WIDTH-1:0] w_ent_rd;
    logic [DEPTH*WIDTH-1:0]     w_ent_data;
    logic                       w_lsu_win;
    logic                       w_push;
    logic                       w_pop;
    wb_src_e                    w_src;
    logic [REG_WIDTH-1:0]       w_win_rd;
    logic [WIDTH-1:0]           w_win_data;
    logic [REG_NUM-1:0]         w_mask_nxt;

    // Writes to x0 and non-writing results are accepted but never queued.
    assign w_lsu_win = lsu_valid && (lsu_rd != '0);
    assign w_push    = alu_valid && !w_full && alu_wen && (alu_rd != '0) && !flush;
    assign w_pop     = !w_lsu_win && !w_empty && !flush;
    assign alu_ready = !w_full;

    wb_fifo #(
        .WIDTH     (WIDTH),
        .REG_WIDTH (REG_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (w_push),
        .push_rd   (alu_rd),
        .push_data (alu_data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .ent_valid (w_ent_valid),
        .ent_rd    (w_ent_rd),
        .ent_data  (w_ent_data)
    );

    always_comb begin
        w_src      = SRC_NONE;
        w_win_rd   = '0;
        w_win_data = '0;
        if (w_lsu_win)  w_src = SRC_LSU;
        else if (w_pop) w_src = SRC_ALU;
        case (w_src)
            SRC_LSU: begin
                w_win_rd   = lsu_rd;
                w_win_data = lsu_data;
            end
            SRC_ALU: begin
                w_win_rd   = w_ent_rd[REG_WIDTH-1:0];
                w_win_data = w_ent_data[WIDTH-1:0];
            end
            default: begin
                w_win_rd   = '0;
                w_win_data = '0;
            end
        endcase
    end

    // Mask is built from the post-edge contents so it lines up with rf_*.
    always_comb begin
        w_mask_nxt = '0;
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ent_valid[i] && !(w_pop && (i == 0)))
                    w_mask_nxt[w_ent_rd[i*REG_WIDTH +: REG_WIDTH]] = 1'b1;
            end
            if (w_push) w_mask_nxt[alu_rd] = 1'b1;
        end
        if (w_src != SRC_NONE) w_mask_nxt[w_win_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            pend_mask <= '0;
        end else begin
            rf_wen    <= (w_src != SRC_NONE);
            pend_mask <= w_mask_nxt;
            if (w_src != SRC_NONE) begin
                rf_waddr <= w_win_rd;
                rf_wdata <= w_win_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [REG_WIDTH-1:0] w_raddr [2];
    assign w_raddr[0] = byp_raddr1;
    assign w_raddr[1] = byp_raddr2;

    // Later matches overwrite earlier ones, so the youngest pending value wins.
    for (genvar gp = 0; gp < 2; gp++) begin : g_byp
        logic             w_hit;
        logic [WIDTH-1:0] w_data;
        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            if (rf_wen && (rf_waddr == w_raddr[gp])) begin
                w_hit  = 1'b1;
                w_data = rf_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_ent_valid[i] && (w_ent_rd[i*REG_WIDTH +: REG_WIDTH] == w_raddr[gp])) begin
                    w_hit  = 1'b1;
                    w_data = w_ent_data[i*WIDTH +: WIDTH];
                end
            end
            if (w_raddr[gp] == '0) begin
                w_hit  = 1'b0;
                w_data = '0;
            end
        end
    end

    assign byp_hit1  = g_byp[0].w_hit;
    assign byp_data1 = g_byp[0].w_data;
    assign byp_hit2  = g_byp[1].w_hit;
    assign byp_data2 = g_byp[1].w_data;
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{byp_raddr1, byp_raddr2, w_ent_data[DEPTH*WIDTH-1:WIDTH]};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Directed + randomized bench for wb_arbiter against a queue model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 2;
    localparam int RN    = 1 << RW;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            alu_valid;
    logic            alu_ready;
    logic            alu_wen;
    logic [RW-1:0]   alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic            lsu_valid;
    logic [RW-1:0]   lsu_rd;
    logic [WIDTH-1:0] lsu_data;
    logic            rf_wen;
    logic [RW-1:0]   rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [RN-1:0]   pend_mask;
    logic [RW-1:0]   byp_raddr1;
    logic [RW-1:0]   byp_raddr2;
    logic            byp_hit1;
    logic            byp_hit2;
    logic [WIDTH-1:0] byp_data1;
    logic [WIDTH-1:0] byp_data2;

    wb_arbiter #(.WIDTH(WIDTH), .REG_WIDTH(RW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wen(alu_wen),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask),
        .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } ent_t;

    // Reference model: pending writes in program order plus the write port.
    ent_t             q[$];
    logic             m_wen;
    logic [RW-1:0]    m_waddr;
    logic [WIDTH-1:0] m_wdata;
    logic [RW-1:0]    wlog[$];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    function automatic logic [RN-1:0] mask_ref();
        logic [RN-1:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (m_wen) m[m_waddr] = 1'b1;
        return m;
    endfunction

    task automatic byp_ref(input logic [RW-1:0] a, output logic h, output logic [WIDTH-1:0] d);
        h = 1'b0;
        d = '0;
        if (m_wen && m_waddr == a) begin h = 1'b1; d = m_wdata; end
        foreach (q[i]) if (q[i].rd == a) begin h = 1'b1; d = q[i].data; end
        if (a == '0) begin h = 1'b0; d = '0; end
    endtask

    task automatic set_alu(input logic v, input logic w, input logic [RW-1:0] rd, input logic [WIDTH-1:0] d);
        alu_valid = v; alu_wen = w; alu_rd = rd; alu_data = d;
    endtask

    task automatic set_lsu(input logic v, input logic [RW-1:0] rd, input logic [WIDTH-1:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    // One clock: check combinational outputs, advance model at the edge, check registers.
    task automatic step(output bit acc);
        logic             h;
        logic [WIDTH-1:0] d;
        bit               rdy;
        ent_t             e;
        if (rst) model_reset();
        rdy = (q.size() < DEPTH);
        acc = alu_valid && rdy;
        chk("alu_ready", alu_ready, rdy);
`ifdef WB_BYPASS_EN
        byp_ref(byp_raddr1, h, d);
`else
        h = 1'b0; d = '0;
`endif
        chk("byp_hit1", byp_hit1, h);
        chk("byp_data1", byp_data1, d);
`ifdef WB_BYPASS_EN
        byp_ref(byp_raddr2, h, d);
`endif
        chk("byp_hit2", byp_hit2, h);
        chk("byp_data2", byp_data2, d);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (lsu_valid && lsu_rd != '0) begin
                m_wen = 1'b1; m_waddr = lsu_rd; m_wdata = lsu_data;
            end else if (!flush && q.size() > 0) begin
                e = q.pop_front();
                m_wen = 1'b1; m_waddr = e.rd; m_wdata = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (flush) q.delete();
            else if (acc && alu_wen && alu_rd != '0) q.push_back({alu_rd, alu_data});
        end
        #1;
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("pend_mask", pend_mask, mask_ref());
        if (rf_wen) wlog.push_back(rf_waddr);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit            acc;
        bit            seen;
        int            cnt;
        logic [RW-1:0] f[$];
        logic [RW-1:0] exp_ord[3];

        rst = 1'b1; flush = 1'b0;
        set_alu(0, 0, 0, 0); set_lsu(0, 0, 0);
        byp_raddr1 = '0; byp_raddr2 = '0;
        model_reset();
        @(negedge clk);
        step(acc); step(acc);
        chk("reset_wen", rf_wen, 1'b0);
        chk("reset_mask", pend_mask, '0);
        chk("reset_ready", alu_ready, 1'b1);
        rst = 1'b0;

        // ALU alone: latency 2, mask set from the cycle after acceptance
        set_alu(1, 1, 5, 'h11);
        step(acc);
        set_alu(0, 0, 0, 0);
        chk("alu_mask_t1", pend_mask[5], 1'b1);
        chk("alu_wen_t1", rf_wen, 1'b0);
        step(acc);
        chk("alu_wen_t2", rf_wen, 1'b1);
        chk("alu_waddr_t2", rf_waddr, 5);
        chk("alu_wdata_t2", rf_wdata, 'h11);
        chk("alu_mask_t2", pend_mask[5], 1'b1);
        step(acc);
        chk("alu_idle_wen", rf_wen, 1'b0);

        // LSU beats a queued ALU entry
        set_alu(1, 1, 3, 'h33);
        step(acc);
        set_alu(0, 0, 0, 0);
        set_lsu(1, 7, 'hAA);
        step(acc);
        chk("conf_first_addr", rf_waddr, 7);
        chk("conf_first_data", rf_wdata, 'hAA);
        set_lsu(0, 0, 0);
        step(acc);
        chk("conf_second_addr", rf_waddr, 3);
        chk("conf_second_data", rf_wdata, 'h33);
        step(acc);

        // Full FIFO under continuous LSU traffic
        wlog.delete();
        set_lsu(1, 20, 'h5);
        set_alu(1, 1, 11, 'h111); step(acc);
        set_alu(1, 1, 12, 'h112); step(acc);
        chk("full_ready", alu_ready, 1'b0);
        set_alu(1, 1, 13, 'h113);
        for (int i = 0; i < 3; i++) step(acc);
        set_lsu(0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(acc);
            seen = acc;
        end
        chk("full_third_accepted", seen, 1'b1);
        set_alu(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(acc);
        f.delete();
        foreach (wlog[i]) if (wlog[i] != 20) f.push_back(wlog[i]);
        exp_ord[0] = 11; exp_ord[1] = 12; exp_ord[2] = 13;
        chk("full_order_n", f.size(), 3);
        for (int i = 0; i < 3; i++) chk("full_order", (i < f.size()) ? f[i] : 5'd0, exp_ord[i]);

        // x0 is swallowed; flush discards queued and same-cycle entries
        wlog.delete();
        set_alu(1, 1, 0, 'h77); step(acc);
        chk("x0_wen", rf_wen, 1'b0);
        chk("x0_mask", pend_mask, '0);
        set_alu(1, 1, 4, 'h44); step(acc);
        set_alu(1, 1, 6, 'h66); flush = 1'b1; step(acc);
        flush = 1'b0; set_alu(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(acc);
        chk("flush_mask", pend_mask, '0);
        cnt = 0;
        foreach (wlog[i]) if (wlog[i] == 4 || wlog[i] == 6) cnt++;
        chk("flush_nowrite", cnt, 0);

        // Reset mid-drain with two queued
        set_lsu(1, 20, 'h9);
        set_alu(1, 1, 14, 'h14); step(acc);
        set_alu(1, 1, 15, 'h15); step(acc);
        set_alu(0, 0, 0, 0); set_lsu(0, 0, 0);
        step(acc);
        rst = 1'b1;
        #1;
        chk("rst_async_wen", rf_wen, 1'b0);
        chk("rst_async_mask", pend_mask, '0);
        chk("rst_async_ready", alu_ready, 1'b1);
        step(acc);
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_mask", pend_mask, '0);
        chk("rst_ready", alu_ready, 1'b1);
        rst = 1'b0;
        step(acc);
        chk("rst_lost_wen", rf_wen, 1'b0);

        // Bypass: youngest of two writes to the same register
        set_lsu(1, 20, 'h1);
        set_alu(1, 1, 9, 'h1); step(acc);
        set_alu(1, 1, 9, 'h2); step(acc);
        set_alu(0, 0, 0, 0);
        byp_raddr1 = 9; byp_raddr2 = 0;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_dir_hit1", byp_hit1, 1'b1);
        chk("byp_dir_data1", byp_data1, 'h2);
`else
        chk("byp_dir_hit1", byp_hit1, 1'b0);
        chk("byp_dir_data1", byp_data1, '0);
`endif
        chk("byp_dir_hit2", byp_hit2, 1'b0);
        step(acc);
        set_lsu(0, 0, 0);
        for (int i = 0; i < 4; i++) step(acc);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 29) == 0);
            set_alu($urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
                    RW'($urandom_range(0, 7)), WIDTH'($urandom));
            set_lsu($urandom_range(0, 4) < 2, RW'($urandom_range(0, 7)), WIDTH'($urandom));
            byp_raddr1 = RW'($urandom_range(0, 7));
            byp_raddr2 = RW'($urandom_range(0, 7));
            step(acc);
        end
        rst = 1'b0; flush = 1'b0;
        set_alu(0, 0, 0, 0); set_lsu(0, 0, 0);
        for (int i = 0; i < 4; i++) step(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
